os_scheduler: RTL and testbench



---
 rtl/os_scheduler_pkg.sv | 37 +++
 rtl/os_scheduler_cc_timer.sv | 54 +++++
 rtl/os_scheduler.sv | 160 ++++++++++++++++
 tb/tb_os_scheduler.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/os_scheduler_pkg.sv
// Shared types and defaults for the ordered-set scheduler.
// Optional feature macro: CC_FRAME_DEFER_EN (see os_scheduler.sv).
package os_scheduler_pkg;

    localparam int CC_PERIOD_DEFAULT = 10000;
    localparam int CC_LEN_DEFAULT    = 6;
    localparam int OS_W_DEFAULT      = 3;
    localparam int CNT_W_DEFAULT     = 16;

    // Ordered-set codes carried on the lane stream.
    typedef enum logic [2:0] {
        OS_IDLE   = 3'd0,
        OS_ALIGN  = 3'd1,
        OS_VERIFY = 3'd2,
        OS_CHBOND = 3'd3,
        OS_CC     = 3'd4,
        OS_SCP    = 3'd5,
        OS_ECP    = 3'd6,
        OS_DATA   = 3'd7
    } ordered_sets_e;

    // Source tag reported alongside each registered ordered set.
    typedef enum logic [1:0] {
        SRC_IDLE = 2'd0,
        SRC_INIT = 2'd1,
        SRC_CC   = 2'd2,
        SRC_DATA = 2'd3
    } os_src_e;

    // Scheduler operating states.
    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1,
        CC   = 2'd2
    } sched_state_e;

endpackage

// File: rtl/os_scheduler_cc_timer.sv
// Clock-compensation timing: free-running period counter that flags the
// cycle before a CC sequence is due, plus the position counter inside a
// running CC sequence.
module cc_timer
    import os_scheduler_pkg::*;
#(
    parameter int CC_PERIOD = CC_PERIOD_DEFAULT,
    parameter int CC_LEN    = CC_LEN_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_cc_start,
    input  logic i_in_cc,
    output logic o_cc_due,
    output logic o_len_last
);

    localparam int PW = (CC_PERIOD > 1) ? $clog2(CC_PERIOD) : 1;
    localparam int LW = (CC_LEN > 1) ? $clog2(CC_LEN) : 1;

    logic [PW-1:0] r_cc_cnt;
    logic [LW-1:0] r_cc_len_cnt;
    logic          w_cc_due;
    logic          w_len_last;

    assign w_cc_due   = (r_cc_cnt == PW'(CC_PERIOD - 1));
    assign w_len_last = (r_cc_len_cnt == LW'(CC_LEN - 1));
    assign o_cc_due   = w_cc_due;
    assign o_len_last = w_len_last;

    // Period counter: held at zero while initializing, otherwise wraps every CC_PERIOD cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cc_cnt <= '0;
        end else if (i_clear || w_cc_due) begin
            r_cc_cnt <= '0;
        end else begin
            r_cc_cnt <= r_cc_cnt + PW'(1);
        end
    end

    // Index of the OS_CC currently on the output; restarts with every new CC sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cc_len_cnt <= '0;
        end else if (i_clear || i_cc_start) begin
            r_cc_len_cnt <= '0;
        end else if (i_in_cc && !w_len_last) begin
            r_cc_len_cnt <= r_cc_len_cnt + LW'(1);
        end
    end

endmodule

// File: rtl/os_scheduler.sv
// Ordered-set scheduler: merges channel-init, clock-compensation and user
// data ordered sets into one registered stream for the lane controller.
// Optional feature macro: CC_FRAME_DEFER_EN -- when defined, a CC that
// falls due mid-frame is held back until the frame's last beat has left.
// A beat is never accepted in a cycle where init_finished is low, because
// the stream is handed back to the initializer on the next edge.
module os_scheduler
    import os_scheduler_pkg::*;
#(
    parameter int CC_PERIOD = CC_PERIOD_DEFAULT,
    parameter int CC_LEN    = CC_LEN_DEFAULT,
    parameter int OS_W      = OS_W_DEFAULT,
    parameter int CNT_W     = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init_finished,
    input  logic [OS_W-1:0]  init_os,
    input  logic             data_req,
    input  logic [OS_W-1:0]  data_os,
    input  logic             data_last,
    output logic             data_ready,
    output logic [OS_W-1:0]  os_out,
    output logic [1:0]       os_src,
    output logic             in_frame,
    output logic [CNT_W-1:0] cc_count
);

    localparam logic [OS_W-1:0] OS_IDLE_CODE = OS_W'(OS_IDLE);
    localparam logic [OS_W-1:0] OS_CC_CODE   = OS_W'(OS_CC);

    sched_state_e     r_state;
    sched_state_e     w_state_next;
    logic [OS_W-1:0]  r_os_out;
    logic [OS_W-1:0]  w_os_next;
    os_src_e          r_os_src;
    os_src_e          w_src_next;
    logic             r_in_frame;
    logic             w_in_frame_next;
    logic [CNT_W-1:0] r_cc_count;
    logic [CNT_W-1:0] w_cc_count_next;

    logic w_cc_due;
    logic w_len_last;
    logic w_clear;
    logic w_run;
    logic w_cc_start;
    logic w_ready;
    logic w_accept;

    assign w_run   = (r_state == RUN);
    assign w_clear = (r_state == INIT) || !init_finished;

`ifdef CC_FRAME_DEFER_EN
    logic r_cc_pending;

    assign w_cc_start = w_run && (w_cc_due || r_cc_pending) && !r_in_frame;

    // Remembers a CC that fell due inside an open frame; further dues are absorbed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cc_pending <= 1'b0;
        end else if (w_clear || w_cc_start) begin
            r_cc_pending <= 1'b0;
        end else if (w_run && w_cc_due && r_in_frame) begin
            r_cc_pending <= 1'b1;
        end
    end
`else
    assign w_cc_start = w_run && w_cc_due;
`endif

    assign w_ready  = w_run && init_finished && !w_cc_start;
    assign w_accept = data_req && w_ready;

    cc_timer #(
        .CC_PERIOD (CC_PERIOD),
        .CC_LEN    (CC_LEN)
    ) u_cc_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_clear),
        .i_cc_start (w_cc_start),
        .i_in_cc    (r_state == CC),
        .o_cc_due   (w_cc_due),
        .o_len_last (w_len_last)
    );

    // Next state and next registered output: init request wins, then CC, then data, else idle.
    always_comb begin
        w_state_next    = r_state;
        w_os_next       = OS_IDLE_CODE;
        w_src_next      = SRC_IDLE;
        w_in_frame_next = r_in_frame;
        w_cc_count_next = r_cc_count;
        if (!init_finished) begin
            w_state_next    = INIT;
            w_os_next       = init_os;
            w_src_next      = SRC_INIT;
            w_in_frame_next = 1'b0;
        end else begin
            unique case (r_state)
                INIT: begin
                    w_state_next = RUN;
                    w_os_next    = init_os;
                    w_src_next   = SRC_INIT;
                end
                RUN: begin
                    if (w_cc_start) begin
                        w_state_next = CC;
                        w_os_next    = OS_CC_CODE;
                        w_src_next   = SRC_CC;
                    end else if (w_accept) begin
                        w_os_next       = data_os;
                        w_src_next      = SRC_DATA;
                        w_in_frame_next = !data_last;
                    end
                end
                CC: begin
                    if (w_len_last) begin
                        w_state_next = RUN;
                        if (r_cc_count != {CNT_W{1'b1}}) begin
                            w_cc_count_next = r_cc_count + CNT_W'(1);
                        end
                    end else begin
                        w_os_next  = OS_CC_CODE;
                        w_src_next = SRC_CC;
                    end
                end
                default: begin
                    w_state_next = INIT;
                end
            endcase
        end
    end

    // State, output stream and frame/statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= INIT;
            r_os_out   <= OS_IDLE_CODE;
            r_os_src   <= SRC_IDLE;
            r_in_frame <= 1'b0;
            r_cc_count <= '0;
        end else begin
            r_state    <= w_state_next;
            r_os_out   <= w_os_next;
            r_os_src   <= w_src_next;
            r_in_frame <= w_in_frame_next;
            r_cc_count <= w_cc_count_next;
        end
    end

    assign data_ready = w_ready;
    assign os_out     = r_os_out;
    assign os_src     = r_os_src;
    assign in_frame   = r_in_frame;
    assign cc_count   = r_cc_count;

endmodule

// File: tb/tb_os_scheduler.sv
// Self-checking bench for os_scheduler with a short CC period, 4-cycle CC
// and a 2-bit statistics counter. A behavioural model tracks what the
// stream should carry each cycle from the scheduling rules.
module tb_os_scheduler;

    localparam int P     = 20;
    localparam int L     = 4;
    localparam int CMAX  = 3;
    localparam logic [2:0] OSCC = 3'd4;
`ifdef CC_FRAME_DEFER_EN
    localparam bit DEFER = 1'b1;
`else
    localparam bit DEFER = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       init_finished = 1'b0;
    logic [2:0] init_os = 3'd0;
    logic       data_req = 1'b0;
    logic [2:0] data_os = 3'd0;
    logic       data_last = 1'b0;
    logic       data_ready;
    logic [2:0] os_out;
    logic [1:0] os_src;
    logic       in_frame;
    logic [1:0] cc_count;

    int nChecks = 0;
    int nFail   = 0;

    // Model: mode 0 = initializing, 1 = running, 2 = emitting CC
    int         mMode = 0;
    int         mPhase = 0;
    int         mLeft = 0;
    bit         mInFrame = 1'b0;
    bit         mPending = 1'b0;
    int         mCcCount = 0;
    logic [2:0] expOs = 3'd0;
    logic [1:0] expSrc = 2'd0;
    logic       expReady = 1'b0;
    logic       obsReady;

    os_scheduler #(
        .CC_PERIOD (P),
        .CC_LEN    (L),
        .OS_W      (3),
        .CNT_W     (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .init_finished (init_finished),
        .init_os       (init_os),
        .data_req      (data_req),
        .data_os       (data_os),
        .data_last     (data_last),
        .data_ready    (data_ready),
        .os_out        (os_out),
        .os_src        (os_src),
        .in_frame      (in_frame),
        .cc_count      (cc_count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Drive one cycle of inputs, record data_ready, advance the model, move past the edge.
    task automatic applyStimulus(input bit fin, input logic [2:0] iOs, input bit req,
                                 input logic [2:0] dOs, input bit last);
        bit due;
        bit start;
        bit accept;
        init_finished = fin;
        init_os       = iOs;
        data_req      = req;
        data_os       = dOs;
        data_last     = last;
        #1;
        obsReady = data_ready;
        due = (mMode != 0) && (mPhase == P - 1);
        if (DEFER) start = (mMode == 1) && (due || mPending) && !mInFrame;
        else       start = (mMode == 1) && due;
        expReady = (mMode == 1) && fin && !start;
        accept   = req && expReady;
        if (!fin) begin
            mMode = 0; mPhase = 0; mLeft = 0; mInFrame = 0; mPending = 0;
            expOs = iOs; expSrc = 2'd1;
        end else if (mMode == 0) begin
            mMode = 1; mPhase = 0;
            expOs = iOs; expSrc = 2'd1;
        end else begin
            mPhase = (mPhase + 1) % P;
            if (mMode == 1) begin
                if (start) begin
                    mMode = 2; mLeft = L - 1; mPending = 0;
                    expOs = OSCC; expSrc = 2'd2;
                end else begin
                    if (DEFER && due && mInFrame) mPending = 1;
                    if (accept) begin
                        expOs = dOs; expSrc = 2'd3; mInFrame = !last;
                    end else begin
                        expOs = 3'd0; expSrc = 2'd0;
                    end
                end
            end else begin
                if (mLeft > 0) begin
                    mLeft--; expOs = OSCC; expSrc = 2'd2;
                end else begin
                    mMode = 1; expOs = 3'd0; expSrc = 2'd0;
                    if (mCcCount < CMAX) mCcCount++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nChecks++; if (os_out !== 3'd0) begin nFail++; $display("[TB] FAIL reset os_out got %0d expected 0", os_out); end
        nChecks++; if (os_src !== 2'd0) begin nFail++; $display("[TB] FAIL reset os_src got %0d expected 0", os_src); end
        nChecks++; if (data_ready !== 1'b0) begin nFail++; $display("[TB] FAIL reset data_ready got %0b expected 0", data_ready); end
        nChecks++; if (in_frame !== 1'b0) begin nFail++; $display("[TB] FAIL reset in_frame got %0b expected 0", in_frame); end
        nChecks++; if (cc_count !== 2'd0) begin nFail++; $display("[TB] FAIL reset cc_count got %0d expected 0", cc_count); end
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_init_follow();
        logic [2:0] v;
        for (int c = 0; c < 8; c++) begin
            v = 3'($urandom_range(0, 7));
            applyStimulus(1'b0, v, 1'b1, 3'd7, 1'b0);
            nChecks++; if (os_out !== v) begin nFail++; $display("[TB] FAIL initFollow os_out got %0d expected %0d", os_out, v); end
            nChecks++; if (os_src !== 2'd1) begin nFail++; $display("[TB] FAIL initFollow os_src got %0d expected 1", os_src); end
            nChecks++; if (obsReady !== 1'b0) begin nFail++; $display("[TB] FAIL initFollow data_ready got %0b expected 0", obsReady); end
            nChecks++; if (cc_count !== 2'd0) begin nFail++; $display("[TB] FAIL initFollow cc_count got %0d expected 0", cc_count); end
        end
    endtask

    task automatic test_cc_timing();
        bit isCc;
        applyStimulus(1'b1, 3'd2, 1'b0, 3'd0, 1'b0);
        for (int i = 1; i <= 45; i++) begin
            applyStimulus(1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
            isCc = ((i >= 20) && (i <= 23)) || ((i >= 40) && (i <= 43));
            nChecks++; if ((os_src == 2'd2) !== isCc) begin nFail++; $display("[TB] FAIL ccTiming cycle %0d cc got %0b expected %0b", i, (os_src == 2'd2), isCc); end
            nChecks++; if (os_out !== expOs) begin nFail++; $display("[TB] FAIL ccTiming os_out got %0d expected %0d", os_out, expOs); end
            nChecks++; if (obsReady !== expReady) begin nFail++; $display("[TB] FAIL ccTiming data_ready got %0b expected %0b", obsReady, expReady); end
        end
        nChecks++; if (cc_count !== 2'd2) begin nFail++; $display("[TB] FAIL ccTiming cc_count got %0d expected 2", cc_count); end
    endtask

    task automatic test_frame_across_cc();
        bit found = 0;
        int beat = 0;
        int ccSeen = 0;
        int dataSeen = 0;
        bit req;
        for (int k = 0; k < 3 * P && !found; k++) begin
            if (mMode == 1 && mPhase == P - 3) found = 1;
            else applyStimulus(1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
        end
        nChecks++; if (!found) begin nFail++; $display("[TB] FAIL frameCc align timeout got 0 expected 1"); end
        for (int c = 0; c < 14; c++) begin
            req = (beat < 5);
            applyStimulus(1'b1, 3'd0, req, 3'($urandom_range(0, 7)), beat == 4);
            if (req && expReady) beat++;
            if (os_src == 2'd3) dataSeen++;
            if (os_src == 2'd2) begin
                ccSeen++;
                nChecks++; if (in_frame !== !DEFER) begin nFail++; $display("[TB] FAIL frameCc in_frame during CC got %0b expected %0b", in_frame, !DEFER); end
            end
            nChecks++; if (os_out !== expOs) begin nFail++; $display("[TB] FAIL frameCc os_out got %0d expected %0d", os_out, expOs); end
            nChecks++; if (os_src !== expSrc) begin nFail++; $display("[TB] FAIL frameCc os_src got %0d expected %0d", os_src, expSrc); end
            nChecks++; if (obsReady !== expReady) begin nFail++; $display("[TB] FAIL frameCc data_ready got %0b expected %0b", obsReady, expReady); end
            nChecks++; if (in_frame !== mInFrame) begin nFail++; $display("[TB] FAIL frameCc in_frame got %0b expected %0b", in_frame, mInFrame); end
        end
        nChecks++; if (ccSeen != L) begin nFail++; $display("[TB] FAIL frameCc cc cycles got %0d expected %0d", ccSeen, L); end
        nChecks++; if (dataSeen != 5) begin nFail++; $display("[TB] FAIL frameCc data beats got %0d expected 5", dataSeen); end
        nChecks++; if (in_frame !== 1'b0) begin nFail++; $display("[TB] FAIL frameCc final in_frame got %0b expected 0", in_frame); end
    endtask

    task automatic test_init_drop();
        bit found = 0;
        int savedCount;
        int firstCc = -1;
        for (int k = 0; k < 3 * P && !found; k++) begin
            if (mMode == 1 && mPhase < P - 6) found = 1;
            else applyStimulus(1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
        end
        applyStimulus(1'b1, 3'd0, 1'b1, 3'd5, 1'b0);
        found = 0;
        for (int k = 0; k < 3 * P && !found; k++) begin
            if (mMode == 2 && mLeft == L - 2) found = 1;
            else applyStimulus(1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
        end
        nChecks++; if (!found) begin nFail++; $display("[TB] FAIL initDrop CC wait timeout got 0 expected 1"); end
        nChecks++; if (in_frame !== mInFrame) begin nFail++; $display("[TB] FAIL initDrop in_frame before drop got %0b expected %0b", in_frame, mInFrame); end
        savedCount = mCcCount;
        applyStimulus(1'b0, 3'd3, 1'b0, 3'd0, 1'b0);
        nChecks++; if (os_src !== 2'd1) begin nFail++; $display("[TB] FAIL initDrop os_src got %0d expected 1", os_src); end
        nChecks++; if (os_out !== 3'd3) begin nFail++; $display("[TB] FAIL initDrop os_out got %0d expected 3", os_out); end
        nChecks++; if (in_frame !== 1'b0) begin nFail++; $display("[TB] FAIL initDrop in_frame got %0b expected 0", in_frame); end
        nChecks++; if (cc_count !== 2'(savedCount)) begin nFail++; $display("[TB] FAIL initDrop cc_count got %0d expected %0d", cc_count, savedCount); end
        applyStimulus(1'b0, 3'd1, 1'b0, 3'd0, 1'b0);
        applyStimulus(1'b1, 3'd2, 1'b0, 3'd0, 1'b0);
        for (int i = 1; i <= 24; i++) begin
            applyStimulus(1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
            if (os_src == 2'd2 && firstCc < 0) firstCc = i;
            nChecks++; if (os_src !== expSrc) begin nFail++; $display("[TB] FAIL initDrop os_src got %0d expected %0d", os_src, expSrc); end
        end
        nChecks++; if (firstCc != 20) begin nFail++; $display("[TB] FAIL initDrop CC restart cycle got %0d expected 20", firstCc); end
    endtask

    task automatic test_saturate();
        for (int c = 0; c < 3 * P + 10; c++) begin
            applyStimulus(1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
            nChecks++; if (cc_count !== 2'(mCcCount)) begin nFail++; $display("[TB] FAIL saturate cc_count got %0d expected %0d", cc_count, mCcCount); end
            nChecks++; if (os_out !== expOs) begin nFail++; $display("[TB] FAIL saturate os_out got %0d expected %0d", os_out, expOs); end
        end
        nChecks++; if (cc_count !== 2'd3) begin nFail++; $display("[TB] FAIL saturate final cc_count got %0d expected 3", cc_count); end
    endtask

    task automatic test_random();
        bit fin;
        for (int c = 0; c < 300; c++) begin
            fin = ($urandom_range(0, 39) != 0);
            applyStimulus(fin, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                          3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
            nChecks++; if (os_out !== expOs) begin nFail++; $display("[TB] FAIL random os_out got %0d expected %0d", os_out, expOs); end
            nChecks++; if (os_src !== expSrc) begin nFail++; $display("[TB] FAIL random os_src got %0d expected %0d", os_src, expSrc); end
            nChecks++; if (obsReady !== expReady) begin nFail++; $display("[TB] FAIL random data_ready got %0b expected %0b", obsReady, expReady); end
            nChecks++; if (in_frame !== mInFrame) begin nFail++; $display("[TB] FAIL random in_frame got %0b expected %0b", in_frame, mInFrame); end
            nChecks++; if (cc_count !== 2'(mCcCount)) begin nFail++; $display("[TB] FAIL random cc_count got %0d expected %0d", cc_count, mCcCount); end
        end
    endtask

    initial begin
        test_reset();
        test_init_follow();
        test_cc_timing();
        test_frame_across_cc();
        test_init_drop();
        test_saturate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
